// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: word-addressed RAM answering MAR/MDR requests after WAIT_CYCLES wait states.
// Define LC3_MEM_MMIO_EN to decode the keyboard/display device registers at xFE00-xFE06.
module lc3_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_busy,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [3:0]        wait_cnt_reg;
  logic              we_reg;
  logic [15:0]       addr_reg;
  logic [15:0]       wdata_reg;
  logic [15:0]       rdata_hold_reg;
  logic [15:0]       ram_q;
  logic [15:0]       load_data;
  logic              accept;
  logic              resp_load;
  logic              dev_hit;
  logic              ram_we;
  logic [ADDR_W-1:0] rd_idx;
  logic [15:0]       ram [2**ADDR_W];

  assign accept    = (state_reg == ST_IDLE) && mem_req;
  assign resp_load = (state_reg == ST_RESP) && !we_reg;

  always_comb begin
    state_next = state_reg;
    mem_ready  = 1'b0;
    mem_busy   = accept;
    case (state_reg)
      ST_IDLE: if (mem_req) state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: begin
        mem_busy = 1'b1;
        if (wait_cnt_reg == WAIT_LAST) state_next = ST_RESP;
      end
      ST_RESP: begin
        mem_busy   = 1'b1;
        mem_ready  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      wait_cnt_reg   <= 4'd0;
      we_reg         <= 1'b0;
      addr_reg       <= 16'h0000;
      wdata_reg      <= 16'h0000;
      rdata_hold_reg <= 16'h0000;
    end else begin
      state_reg      <= state_next;
      rdata_hold_reg <= mem_rdata;
      if (accept) begin
        we_reg       <= mem_we;
        addr_reg     <= mem_addr;
        wdata_reg    <= mem_wdata;
        wait_cnt_reg <= 4'd0;
      end else if (state_reg == ST_WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + 4'd1;
      end
    end
  end

  // Load data is only presented during RESP; otherwise the previous response is held.
  assign mem_rdata = resp_load ? load_data : rdata_hold_reg;

  // The read index follows the live address on the accept edge so zero-wait loads are ready in RESP.
  assign rd_idx = (state_reg == ST_IDLE) ? mem_addr[ADDR_W-1:0] : addr_reg[ADDR_W-1:0];
  assign ram_we = (state_reg == ST_RESP) && we_reg && !dev_hit;

  always_ff @(posedge clk) begin
    if (ram_we) ram[addr_reg[ADDR_W-1:0]] <= wdata_reg;
    ram_q <= ram[rd_idx];
  end

`ifdef LC3_MEM_MMIO_EN
  logic        kbd_rdy_reg;
  logic [7:0]  kbd_reg;
  logic [15:0] dev_rdata;

  assign dev_hit = (addr_reg[15:3] == 13'h1FC0) && !addr_reg[0];

  always_comb begin
    dev_rdata = 16'h0000;
    case (addr_reg[2:1])
      2'd0:    dev_rdata = {kbd_rdy_reg, 15'b0};
      2'd1:    dev_rdata = {8'h00, kbd_reg};
      2'd2:    dev_rdata = 16'h8000;
      default: dev_rdata = 16'h0000;
    endcase
  end

  assign load_data = dev_hit ? dev_rdata : ram_q;

  // A new key strobe outranks the KBDR read clear so the fresh key is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbd_rdy_reg <= 1'b0;
      kbd_reg     <= 8'h00;
    end else if (kbd_valid) begin
      kbd_rdy_reg <= 1'b1;
      kbd_reg     <= kbd_data;
    end else if (resp_load && dev_hit && (addr_reg[2:1] == 2'd1)) begin
      kbd_rdy_reg <= 1'b0;
    end
  end

  assign disp_valid = (state_reg == ST_RESP) && we_reg && dev_hit && (addr_reg[2:1] == 2'd3);
  assign disp_data  = disp_valid ? wdata_reg[7:0] : 8'h00;
`else
  logic unused_ok;

  assign dev_hit    = 1'b0;
  assign load_data  = ram_q;
  assign disp_valid = 1'b0;
  assign disp_data  = 8'h00;
  assign unused_ok  = &{1'b0, kbd_valid, kbd_data, addr_reg[15:ADDR_W]};
`endif

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: two instances (0 and 3 wait states) against an array model.
// Follows LC3_MEM_MMIO_EN the same way the design does.
module tb_lc3_mem_responder;

  localparam int W0 = 0;
  localparam int W1 = 3;

  logic        clk;
  logic        rst_n      [2];
  logic        mem_req    [2];
  logic        mem_we     [2];
  logic [15:0] mem_addr   [2];
  logic [15:0] mem_wdata  [2];
  logic [15:0] mem_rdata  [2];
  logic        mem_ready  [2];
  logic        mem_busy   [2];
  logic        kbd_valid  [2];
  logic [7:0]  kbd_data   [2];
  logic        disp_valid [2];
  logic [7:0]  disp_data  [2];

  logic [15:0] model   [2][1024];
  logic [15:0] last_rd [2];
  int          n_checks;
  int          n_fail;
  int          disp_cnt;

  lc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .mem_req(mem_req[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .mem_ready(mem_ready[0]), .mem_busy(mem_busy[0]), .kbd_valid(kbd_valid[0]),
    .kbd_data(kbd_data[0]), .disp_valid(disp_valid[0]), .disp_data(disp_data[0])
  );

  lc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .mem_req(mem_req[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .mem_ready(mem_ready[1]), .mem_busy(mem_busy[1]), .kbd_valid(kbd_valid[1]),
    .kbd_data(kbd_data[1]), .disp_valid(disp_valid[1]), .disp_data(disp_data[1])
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (disp_valid[0]) disp_cnt <= disp_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves any RESP cycle and lands on a falling edge with the DUTs idle.
  task automatic idle_gap();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_access(input int d, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input bit check_busy,
                           output logic [15:0] rdata, output int cycles,
                           output logic saw_disp, output logic [7:0] disp_d);
    mem_we[d]    = we;
    mem_addr[d]  = addr;
    mem_wdata[d] = wdata;
    mem_req[d]   = 1'b1;
    if (check_busy) begin
      #1;
      chk("busy_on_accept", 32'(mem_busy[d]), 32'd1);
    end
    cycles = 0;
    while (cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (mem_ready[d]) break;
    end
    rdata      = mem_rdata[d];
    saw_disp   = disp_valid[d];
    disp_d     = disp_data[d];
    mem_req[d] = 1'b0;
  endtask

  task automatic txn(input int d, input logic we, input logic [15:0] addr,
                     input logic [15:0] wdata, input bit b2b);
    logic [15:0] rd;
    int          cyc;
    logic        sd;
    logic [7:0]  dd;
    int          idx;
    int          exp_lat;
    if (!b2b) begin
      idle_gap();
      chk("ready_low_idle", 32'(mem_ready[d]), 32'd0);
    end
    exp_lat = wait_of(d) + 1 + (b2b ? 1 : 0);
    do_access(d, we, addr, wdata, !b2b, rd, cyc, sd, dd);
    idx = int'(addr) % 1024;
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("busy_in_resp", 32'(mem_busy[d]), 32'd1);
    chk("no_disp", 32'(sd), 32'd0);
    if (we) begin
      chk("store_rdata_hold", 32'(rd), 32'(last_rd[d]));
      model[d][idx] = wdata;
    end else begin
      chk("load_rdata", 32'(rd), 32'(model[d][idx]));
      last_rd[d] = model[d][idx];
    end
    $display("txn dut%0d %s addr=%h wdata=%h rdata=%h lat=%0d disp=%h",
             d, we ? "ST" : "LD", addr, wdata, rd, cyc, dd);
  endtask

`ifdef LC3_MEM_MMIO_EN
  task automatic dev_read(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    logic [15:0] rd;
    int          cyc;
    logic        sd;
    logic [7:0]  dd;
    idle_gap();
    do_access(0, 1'b0, addr, 16'h0000, 1'b1, rd, cyc, sd, dd);
    chk({tag, "_lat"}, 32'(cyc), 32'(W0 + 1));
    chk(tag, 32'(rd), 32'(exp));
    last_rd[0] = exp;
    $display("txn dut0 LD addr=%h rdata=%h lat=%0d disp=%h", addr, rd, cyc, dd);
  endtask
`endif

  initial begin
    logic [15:0] rd;
    int          cyc;
    logic        sd;
    logic [7:0]  dd;
    int          c0;
    int          prev_d;

    clk = 1'b0;
    n_checks = 0;
    n_fail = 0;
    disp_cnt = 0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; mem_req[d] = 1'b0; mem_we[d] = 1'b0;
      mem_addr[d] = 16'h0000; mem_wdata[d] = 16'h0000;
      kbd_valid[d] = 1'b0; kbd_data[d] = 8'h00;
      last_rd[d] = 16'h0000;
    end
    for (int i = 0; i < 1024; i++) begin
      model[0][i] = 16'($urandom);
      model[1][i] = 16'($urandom);
      dut0.ram[i] = model[0][i];
      dut1.ram[i] = model[1][i];
    end
    model[0][0]  = 16'h1234; dut0.ram[0]  = 16'h1234;
    model[1][16] = 16'h1111; dut1.ram[16] = 16'h1111;

    // Reset values
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(mem_ready[d]), 32'd0);
      chk("rst_busy", 32'(mem_busy[d]), 32'd0);
      chk("rst_rdata", 32'(mem_rdata[d]), 32'd0);
      chk("rst_disp_valid", 32'(disp_valid[d]), 32'd0);
      chk("rst_disp_data", 32'(disp_data[d]), 32'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Zero-wait load of x3000
    txn(0, 1'b0, 16'h3000, 16'h0000, 1'b0);
    chk("load_x3000", 32'(mem_rdata[0]), 32'h1234);

    // Three-wait store then back-to-back load
    txn(1, 1'b1, 16'h0005, 16'hBEEF, 1'b0);
    txn(1, 1'b0, 16'h0005, 16'h0000, 1'b1);
    chk("store_then_load", 32'(mem_rdata[1]), 32'hBEEF);

    // Address aliasing
    txn(0, 1'b1, 16'h0400, 16'h00AA, 1'b0);
    txn(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("alias_load", 32'(mem_rdata[0]), 32'h00AA);

    // Reset during WAIT aborts the store
    idle_gap();
    mem_we[1] = 1'b1; mem_addr[1] = 16'h0010; mem_wdata[1] = 16'h5555; mem_req[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n[1] = 1'b0;
    mem_req[1] = 1'b0;
    #1;
    chk("abort_ready", 32'(mem_ready[1]), 32'd0);
    chk("abort_busy", 32'(mem_busy[1]), 32'd0);
    chk("abort_rdata", 32'(mem_rdata[1]), 32'd0);
    chk("abort_disp", 32'(disp_valid[1]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_ready", 32'(mem_ready[1]), 32'd0);
    end
    @(negedge clk);
    rst_n[1] = 1'b1;
    last_rd[1] = 16'h0000;
    txn(1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    chk("abort_no_write", 32'(mem_rdata[1]), 32'h1111);

    // Random traffic against the array model
    prev_d = -1;
    for (int k = 0; k < 80; k++) begin
      int          d;
      logic [15:0] a;
      bit          b;
      d = int'($urandom_range(0, 1));
      a = 16'($urandom);
      if (a[15:3] == 13'h1FC0) a = a ^ 16'h0100;
      b = (d == prev_d) && ($urandom_range(0, 2) == 0);
      txn(d, 1'($urandom), a, 16'($urandom), b);
      prev_d = d;
    end

`ifdef LC3_MEM_MMIO_EN
    // Keyboard status/data and display
    idle_gap();
    kbd_valid[0] = 1'b1; kbd_data[0] = 8'h41;
    @(negedge clk);
    kbd_valid[0] = 1'b0;
    dev_read(16'hFE00, 16'h8000, "kbsr_set");
    dev_read(16'hFE02, 16'h0041, "kbdr_read");
    dev_read(16'hFE00, 16'h0000, "kbsr_cleared");
    dev_read(16'hFE04, 16'h8000, "dsr_read");

    idle_gap();
    c0 = disp_cnt;
    do_access(0, 1'b1, 16'hFE06, 16'h0048, 1'b1, rd, cyc, sd, dd);
    chk("ddr_lat", 32'(cyc), 32'(W0 + 1));
    chk("ddr_disp_valid", 32'(sd), 32'd1);
    chk("ddr_disp_data", 32'(dd), 32'h48);
    chk("ddr_rdata_hold", 32'(rd), 32'(last_rd[0]));
    $display("txn dut0 ST addr=fe06 wdata=0048 lat=%0d disp=%h", cyc, dd);
    @(posedge clk);
    #1;
    chk("ddr_single_pulse", 32'(disp_cnt - c0), 32'd1);
    chk("ddr_pulse_end", 32'(disp_valid[0]), 32'd0);
    idle_gap();
    do_access(0, 1'b1, 16'hFE00, 16'h7777, 1'b1, rd, cyc, sd, dd);
    chk("kbsr_store_lat", 32'(cyc), 32'(W0 + 1));
    $display("txn dut0 ST addr=fe00 wdata=7777 lat=%0d disp=%h", cyc, dd);
    txn(0, 1'b0, 16'h0206, 16'h0000, 1'b0);
    txn(0, 1'b0, 16'h0200, 16'h0000, 1'b0);

    // Key strobe coinciding with the KBDR read clear
    idle_gap();
    mem_we[0] = 1'b0; mem_addr[0] = 16'hFE02; mem_req[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("kbdr2_ready", 32'(mem_ready[0]), 32'd1);
    chk("kbdr2_old_key", 32'(mem_rdata[0]), 32'h0041);
    $display("txn dut0 LD addr=fe02 rdata=%h with kbd_valid x42", mem_rdata[0]);
    mem_req[0] = 1'b0;
    kbd_valid[0] = 1'b1; kbd_data[0] = 8'h42;
    @(posedge clk);
    #1;
    kbd_valid[0] = 1'b0;
    last_rd[0] = 16'h0041;
    dev_read(16'hFE00, 16'h8000, "kbsr_set_wins");
    dev_read(16'hFE02, 16'h0042, "kbdr_new_key");
`else
    // Device window is plain RAM
    c0 = disp_cnt;
    txn(0, 1'b1, 16'hFE06, 16'h0033, 1'b0);
    txn(0, 1'b0, 16'hFE06, 16'h0000, 1'b0);
    chk("ram_fe06_load", 32'(mem_rdata[0]), 32'h0033);
    chk("no_disp_pulse", 32'(disp_cnt - c0), 32'd0);
    chk("disp_data_tied", 32'(disp_data[0]), 32'd0);
    kbd_valid[0] = 1'b1; kbd_data[0] = 8'h41;
    @(negedge clk);
    kbd_valid[0] = 1'b0;
    txn(0, 1'b0, 16'hFE00, 16'h0000, 1'b0);
`endif

    idle_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
